// File: rtl/dtm_dmi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dtm_dmi_ctrl
// Purpose  : DTM-side data-register controller behind the JTAG TAP. Owns the
//            DTMCS and DMI shift registers, converts TAP capture/shift/update
//            strobes into DMI request/response handshakes towards the Debug
//            Module, and tracks the sticky dmistat error state including
//            dmireset / dmihardreset handling.
// Ports    : tck_i/trst_i          clock, async active-high reset
//            dmi_clear_i           TAP in Test-Logic-Reset (sync clear)
//            capture_i/shift_i/update_i, tdi_i   TAP DR strobes and data
//            dtmcs_select_i/dmi_select_i         current IR decode
//            dtmcs_tdo_o/dmi_tdo_o               serial data out
//            dmi_req_*             request channel to the DM
//            dmi_resp_*            response channel from the DM
//            dmi_hardreset_o       one-cycle pulse resetting the DMI/DM side
// Options  : DTM_DMI_TIMEOUT_EN    abort requests that stay outstanding for
//                                  TIMEOUT_CYCLES tck cycles
// Revision : 1.0  initial release
// ============================================================================
module dtm_dmi_ctrl #(
   parameter int unsigned ABITS          = 7,
   parameter logic [2:0]  IDLE_CYCLES    = 3'd1,
   parameter logic [3:0]  DTM_VERSION    = 4'd1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             tck_i,
   input  logic             trst_i,
   input  logic             dmi_clear_i,
   input  logic             capture_i,
   input  logic             shift_i,
   input  logic             update_i,
   input  logic             tdi_i,
   input  logic             dtmcs_select_i,
   input  logic             dmi_select_i,
   output logic             dtmcs_tdo_o,
   output logic             dmi_tdo_o,
   output logic             dmi_req_valid_o,
   input  logic             dmi_req_ready_i,
   output logic [ABITS-1:0] dmi_req_addr_o,
   output logic [1:0]       dmi_req_op_o,
   output logic [31:0]      dmi_req_data_o,
   input  logic             dmi_resp_valid_i,
   output logic             dmi_resp_ready_o,
   input  logic [31:0]      dmi_resp_data_i,
   input  logic [1:0]       dmi_resp_op_i,
   output logic             dmi_hardreset_o
);

   localparam int unsigned DMI_W = ABITS + 34;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [1:0] OP_BUSY  = 2'd3;

   localparam logic [1:0] STICKY_NONE   = 2'd0;
   localparam logic [1:0] STICKY_FAILED = 2'd2;
   localparam logic [1:0] STICKY_BUSY   = 2'd3;

   localparam logic [5:0] ABITS_FIELD = 6'(ABITS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e           state_q,     state_d;
   logic [1:0]       sticky_q,    sticky_d;
   logic [ABITS-1:0] addr_q,      addr_d;
   logic [31:0]      data_q,      data_d;
   logic [1:0]       op_q,        op_d;
   logic [31:0]      dtmcs_sr_q,  dtmcs_sr_d;
   logic [DMI_W-1:0] dmi_sr_q,    dmi_sr_d;
   logic             hardreset_q, hardreset_d;

   // ------------------------------------------------------------------------
   // Decoded strobes and field views
   // ------------------------------------------------------------------------
   logic             busy;
   logic             dtmcs_cap, dtmcs_shift, dtmcs_upd;
   logic             dmi_cap,   dmi_shift,   dmi_upd;
   logic [31:0]      dtmcs_rdata;
   logic [ABITS-1:0] upd_addr;
   logic [31:0]      upd_data;
   logic [1:0]       upd_op;
   logic             resp_done;
   logic             timeout_hit;

   assign busy        = (state_q != ST_IDLE);
   assign dtmcs_cap   = capture_i & dtmcs_select_i;
   assign dtmcs_shift = shift_i   & dtmcs_select_i;
   assign dtmcs_upd   = update_i  & dtmcs_select_i;
   assign dmi_cap     = capture_i & dmi_select_i;
   assign dmi_shift   = shift_i   & dmi_select_i;
   assign dmi_upd     = update_i  & dmi_select_i;

   // dmireset/dmihardreset read back as zero; they only act on update.
   assign dtmcs_rdata = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_CYCLES,
                         sticky_q, ABITS_FIELD, DTM_VERSION};

   assign upd_addr  = dmi_sr_q[DMI_W-1:34];
   assign upd_data  = dmi_sr_q[33:2];
   assign upd_op    = dmi_sr_q[1:0];

   assign resp_done = (state_q == ST_RESP) & dmi_resp_valid_i;

   // ------------------------------------------------------------------------
   // Optional request timeout
   // ------------------------------------------------------------------------
`ifdef DTM_DMI_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // A response arriving in the very last cycle still completes normally.
   assign timeout_hit = busy & ~resp_done &
                        (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_cnt_d = '0;
      if (busy && !timeout_hit) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
      if (dmi_clear_i || (dtmcs_upd && dtmcs_sr_q[17])) begin
         tmo_cnt_d = '0;
      end
   end

   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   logic timeout_unused;

   // Without the timeout feature the FSM waits for the DM indefinitely.
   assign timeout_hit    = 1'b0;
   assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

   // ------------------------------------------------------------------------
   // Next-state logic. Later assignments override earlier ones, which encodes
   // the priority: clear > hardreset > dmireset > busy/response sticky.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      sticky_d    = sticky_q;
      addr_d      = addr_q;
      data_d      = data_q;
      op_d        = op_q;
      dtmcs_sr_d  = dtmcs_sr_q;
      dmi_sr_d    = dmi_sr_q;
      hardreset_d = 1'b0;

      // Shift registers
      if (dtmcs_cap) begin
         dtmcs_sr_d = dtmcs_rdata;
      end else if (dtmcs_shift) begin
         dtmcs_sr_d = {tdi_i, dtmcs_sr_q[31:1]};
      end

      if (dmi_cap) begin
         dmi_sr_d = {addr_q, data_q, (busy ? OP_BUSY : sticky_q)};
      end else if (dmi_shift) begin
         dmi_sr_d = {tdi_i, dmi_sr_q[DMI_W-1:1]};
      end

      // Request / response FSM
      unique case (state_q)
         ST_IDLE: begin
            if (dmi_upd && (sticky_q == STICKY_NONE) &&
                ((upd_op == OP_READ) || (upd_op == OP_WRITE))) begin
               addr_d  = upd_addr;
               data_d  = upd_data;
               op_d    = upd_op;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (dmi_req_ready_i) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (dmi_resp_valid_i) begin
               // Writes keep the written data visible on the next capture.
               if (op_q == OP_READ) begin
                  data_d = dmi_resp_data_i;
               end
               if ((dmi_resp_op_i != 2'd0) && (sticky_q != STICKY_BUSY)) begin
                  sticky_d = STICKY_FAILED;
               end
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Touching the DMI register while a transaction is outstanding is a
      // busy error; an update is only checked if no error is pending yet.
      if (dmi_cap && busy) begin
         sticky_d = STICKY_BUSY;
      end
      if (dmi_upd && busy && (sticky_q == STICKY_NONE)) begin
         sticky_d = STICKY_BUSY;
      end

      if (timeout_hit) begin
         state_d     = ST_IDLE;
         hardreset_d = 1'b1;
         if (sticky_d != STICKY_BUSY) begin
            sticky_d = STICKY_FAILED;
         end
      end

      // dtmcs write: bit 16 = dmireset, bit 17 = dmihardreset
      if (dtmcs_upd) begin
         if (dtmcs_sr_q[16]) begin
            sticky_d = STICKY_NONE;
         end
         if (dtmcs_sr_q[17]) begin
            sticky_d    = STICKY_NONE;
            state_d     = ST_IDLE;
            hardreset_d = 1'b1;
         end
      end

      // Test-Logic-Reset: full clear without a hardreset pulse
      if (dmi_clear_i) begin
         state_d     = ST_IDLE;
         sticky_d    = STICKY_NONE;
         addr_d      = '0;
         data_d      = '0;
         op_d        = OP_NOP;
         dtmcs_sr_d  = '0;
         dmi_sr_d    = '0;
         hardreset_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         state_q     <= ST_IDLE;
         sticky_q    <= STICKY_NONE;
         addr_q      <= '0;
         data_q      <= '0;
         op_q        <= OP_NOP;
         dtmcs_sr_q  <= '0;
         dmi_sr_q    <= '0;
         hardreset_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sticky_q    <= sticky_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         op_q        <= op_d;
         dtmcs_sr_q  <= dtmcs_sr_d;
         dmi_sr_q    <= dmi_sr_d;
         hardreset_q <= hardreset_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign dtmcs_tdo_o      = dtmcs_sr_q[0];
   assign dmi_tdo_o        = dmi_sr_q[0];
   assign dmi_req_valid_o  = (state_q == ST_REQ);
   assign dmi_req_addr_o   = addr_q;
   assign dmi_req_op_o     = op_q;
   assign dmi_req_data_o   = data_q;
   assign dmi_resp_ready_o = (state_q == ST_RESP);
   assign dmi_hardreset_o  = hardreset_q;

endmodule
`default_nettype wire
